uart_4b5b_bridge: RTL and testbench



---
 rtl/uart_4b5b_bridge.sv | 173 +++++++++++++++++
 tb/tb_uart_4b5b_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_4b5b_bridge.sv
// RS-232 8N1 receiver feeding a byte FIFO, drained by a 4B5B-coded serial transmitter.
// Errors are sticky and cleared by CLR_ERR; a coincident new error wins over the clear.
module uart_4b5b_bridge #(
  parameter int RX_DIV  = 54,
  parameter int TX_DIV  = 43,
  parameter int FIFO_AW = 4
) (
  input  logic               CLK_50M,
  input  logic               RST_N,
  input  logic               RS232_DCE_RXD,
  input  logic               CLR_ERR,
  output logic               RS232_DTE_TXD,
  output logic [7:0]         LED,
  output logic               FRAME_ERR,
  output logic               OVERRUN,
  output logic [FIFO_AW:0]   FIFO_LEVEL
);

  localparam int RCW = $clog2(RX_DIV);
  localparam int TCW = $clog2(TX_DIV);
  localparam int DEPTH = 2**FIFO_AW;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic       {T_IDLE, T_SHIFT} tx_st_t;

  function automatic logic [4:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 5'b11110;  4'h1: enc = 5'b01001;
      4'h2: enc = 5'b10100;  4'h3: enc = 5'b10101;
      4'h4: enc = 5'b01010;  4'h5: enc = 5'b01011;
      4'h6: enc = 5'b01110;  4'h7: enc = 5'b01111;
      4'h8: enc = 5'b10010;  4'h9: enc = 5'b10011;
      4'hA: enc = 5'b10110;  4'hB: enc = 5'b10111;
      4'hC: enc = 5'b11010;  4'hD: enc = 5'b11011;
      4'hE: enc = 5'b11100;  default: enc = 5'b11101;
    endcase
  endfunction

  // ---------------- input synchronizer
  logic rx_meta, rxs;
  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) {rxs, rx_meta} <= 2'b11;
    else        {rxs, rx_meta} <= {rx_meta, RS232_DCE_RXD};

  // ---------------- receiver
  rx_st_t         rx_st;
  logic [RCW-1:0] rx_cnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_sr;
  logic           stop_smp, push, ovr_ev, ferr_ev;
  logic           full, empty, pop;

  assign stop_smp = (rx_st == R_STOP) && (rx_cnt == '0);
  assign push     = stop_smp &&  rxs && !full;
  assign ovr_ev   = stop_smp &&  rxs &&  full;
  assign ferr_ev  = stop_smp && !rxs;

  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      rx_st  <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sr  <= '0;
      LED    <= '0;
    end else begin
      case (rx_st)
        R_IDLE:
          if (!rxs) begin
            rx_cnt <= RCW'(RX_DIV/2 - 1);
            rx_st  <= R_START;
          end
        R_START:
          if (rx_cnt != '0)  rx_cnt <= rx_cnt - RCW'(1);
          else if (rxs)      rx_st  <= R_IDLE;   // start bit gone by mid-bit: glitch
          else begin
            rx_cnt <= RCW'(RX_DIV - 1);
            rx_bit <= '0;
            rx_st  <= R_DATA;
          end
        R_DATA:
          if (rx_cnt != '0) rx_cnt <= rx_cnt - RCW'(1);
          else begin
            rx_sr  <= {rxs, rx_sr[7:1]};
            rx_cnt <= RCW'(RX_DIV - 1);
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= R_STOP;
          end
        default:
          if (rx_cnt != '0) rx_cnt <= rx_cnt - RCW'(1);
          else begin
            if (push) LED <= rx_sr;
            rx_st <= R_IDLE;
          end
      endcase
    end

  // ---------------- FIFO
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wp, rp;
  logic [7:0]       fifo_rd;

  assign full       = (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]) && (wp[FIFO_AW] != rp[FIFO_AW]);
  assign empty      = (wp == rp);
  assign fifo_rd    = mem[rp[FIFO_AW-1:0]];
  assign FIFO_LEVEL = wp - rp;

  always_ff @(posedge CLK_50M)
    if (push) mem[wp[FIFO_AW-1:0]] <= rx_sr;

  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end

  // ---------------- transmitter
  tx_st_t         tx_st;
  logic [TCW-1:0] tx_cnt;
  logic [3:0]     tx_bit;
  logic [10:0]    tx_sh;
  logic [11:0]    tx_frame;

  assign pop      = (tx_st == T_IDLE) && !empty;
  assign tx_frame = {1'b1, enc(fifo_rd[7:4]), enc(fifo_rd[3:0]), 1'b0};

  // The start bit goes straight to the pin at load; the shifter holds only bits 11..1.
  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      tx_st         <= T_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_sh         <= '1;
      RS232_DTE_TXD <= 1'b1;
    end else begin
      case (tx_st)
        T_IDLE:
          if (pop) begin
            tx_sh         <= tx_frame[11:1];
            RS232_DTE_TXD <= tx_frame[0];
            tx_cnt        <= TCW'(TX_DIV - 1);
            tx_bit        <= '0;
            tx_st         <= T_SHIFT;
          end
        default:
          if (tx_cnt != '0) tx_cnt <= tx_cnt - TCW'(1);
          else if (tx_bit == 4'd11) begin
            RS232_DTE_TXD <= 1'b1;
            tx_st         <= T_IDLE;
          end else begin
            RS232_DTE_TXD <= tx_sh[0];
            tx_sh         <= {1'b1, tx_sh[10:1]};
            tx_cnt        <= TCW'(TX_DIV - 1);
            tx_bit        <= tx_bit + 4'd1;
          end
      endcase
    end

  // ---------------- sticky error flags
  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (ferr_ev)      FRAME_ERR <= 1'b1;
      else if (CLR_ERR) FRAME_ERR <= 1'b0;
      if (ovr_ev)       OVERRUN   <= 1'b1;
      else if (CLR_ERR) OVERRUN   <= 1'b0;
    end

endmodule

// File: tb/tb_uart_4b5b_bridge.sv
// Bench for uart_4b5b_bridge: default instance plus a slow-TX / shallow-FIFO instance.
module tb_uart_4b5b_bridge;

  localparam int RX_DIV  = 54;
  localparam int TX_DIV0 = 43;
  localparam int TX_DIV1 = 200;

  logic       clk = 1'b0;
  logic       rst_n, clr, rxd0, rxd1;
  logic       txd0, txd1, ferr0, ferr1, ovr0, ovr1;
  logic [7:0] led0, led1;
  logic [4:0] lvl0;
  logic [2:0] lvl1;

  always #10 clk = ~clk;

  uart_4b5b_bridge dut0 (
    .CLK_50M(clk), .RST_N(rst_n), .RS232_DCE_RXD(rxd0), .CLR_ERR(clr),
    .RS232_DTE_TXD(txd0), .LED(led0), .FRAME_ERR(ferr0), .OVERRUN(ovr0),
    .FIFO_LEVEL(lvl0));

  uart_4b5b_bridge #(.TX_DIV(TX_DIV1), .FIFO_AW(2)) dut1 (
    .CLK_50M(clk), .RST_N(rst_n), .RS232_DCE_RXD(rxd1), .CLR_ERR(clr),
    .RS232_DTE_TXD(txd1), .LED(led1), .FRAME_ERR(ferr1), .OVERRUN(ovr1),
    .FIFO_LEVEL(lvl1));

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int maxlvl = 0;
  logic [11:0] q0[$], q1[$];
  int          st0[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference coder: frame bit i is the i-th bit on the line.
  localparam logic [4:0] ENC [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101};

  function automatic logic [11:0] model_frame(input logic [7:0] b);
    logic [4:0] lo, hi;
    logic [11:0] f;
    lo = ENC[b[3:0]];
    hi = ENC[b[7:4]];
    f[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f[1+i] = lo[i];
      f[6+i] = hi[i];
    end
    f[11] = 1'b1;
    return f;
  endfunction

  // Line monitor: mid-bit sampling of each coded frame.
  task automatic mon(input int sel, input int div);
    logic [11:0] f;
    int st;
    forever begin
      if (sel == 0) @(negedge txd0); else @(negedge txd1);
      st = cyc;
      repeat (div/2) @(posedge clk);
      #1 f[0] = (sel == 0) ? txd0 : txd1;
      for (int i = 1; i < 12; i++) begin
        repeat (div) @(posedge clk);
        #1 f[i] = (sel == 0) ? txd0 : txd1;
      end
      if (sel == 0) begin q0.push_back(f); st0.push_back(st); end
      else q1.push_back(f);
    end
  endtask

  initial mon(0, TX_DIV0);
  initial mon(1, TX_DIV1);
  initial forever begin
    @(posedge clk); #1;
    if (int'(lvl0) > maxlvl) maxlvl = int'(lvl0);
  end

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel == 0) rxd0 = f[i]; else rxd1 = f[i];
      repeat (RX_DIV) @(negedge clk);
    end
    if (sel == 0) rxd0 = 1'b1; else rxd1 = 1'b1;
  endtask

  task automatic wait_q(input int sel, input int n, input int budget);
    int k = 0;
    while (((sel == 0) ? q0.size() : q1.size()) < n && k < budget) begin
      @(posedge clk); k++;
    end
    if (k >= budget) chk("frame_timeout", (sel == 0) ? q0.size() : q1.size(), n);
  endtask

  task automatic check_frames(input int sel, input string tag, input logic [7:0] exp[$]);
    foreach (exp[i]) begin
      if (((sel == 0) ? q0.size() : q1.size()) == 0) chk({tag, "_missing"}, 0, model_frame(exp[i]));
      else if (sel == 0) chk(tag, q0.pop_front(), model_frame(exp[i]));
      else               chk(tag, q1.pop_front(), model_frame(exp[i]));
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp[$];
    logic [7:0] b, last_good;
    logic any_bad, bad;
    int t_drv, lat, f;

    rst_n = 1'b0; clr = 1'b0; rxd0 = 1'b1; rxd1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd0, 1'b1);
    chk("rst_led", led0, 8'h00);
    chk("rst_ferr", ferr0, 1'b0);
    chk("rst_ovr", ovr0, 1'b0);
    chk("rst_lvl", lvl0, 0);
    chk("rst_txd1", txd1, 1'b1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single 0xA5 with exact line bits and latency
    q0.delete(); st0.delete();
    t_drv = cyc;
    send_byte(0, 8'hA5, 1'b1);
    wait_q(0, 1, 1500);
    if (q0.size() > 0) begin
      chk("a5_bits", q0.pop_front(), 12'b1101_1001_0110);
      lat = st0.pop_front() - t_drv;
      chk("a5_latency_window", (lat >= 514 && lat <= 519), 1);
    end
    chk("a5_led", led0, 8'hA5);
    chk("a5_flags", {ferr0, ovr0}, 2'b00);

    // single 0x00
    q0.delete(); st0.delete();
    send_byte(0, 8'h00, 1'b1);
    wait_q(0, 1, 1500);
    if (q0.size() > 0) chk("zero_bits", q0.pop_front(), 12'b1111_1011_1100);
    chk("zero_flags", {ferr0, ovr0}, 2'b00);
    chk("zero_led", led0, 8'h00);

    // 32 back-to-back bytes
    q0.delete(); st0.delete(); exp.delete(); maxlvl = 0;
    for (int i = 0; i < 32; i++) begin
      send_byte(0, 8'(i), 1'b1);
      exp.push_back(8'(i));
    end
    wait_q(0, 32, 2000);
    check_frames(0, "b2b_frame", exp);
    chk("b2b_maxlvl_le1", (maxlvl <= 1), 1);
    chk("b2b_ovr", ovr0, 1'b0);

    // randomized traffic with occasional bad stop bits
    q0.delete(); st0.delete(); exp.delete();
    any_bad = 1'b0; last_good = led0;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      send_byte(0, b, !bad);
      if (bad) any_bad = 1'b1;
      else begin exp.push_back(b); last_good = b; end
      repeat ((bad ? RX_DIV : 0) + $urandom_range(0, 40)) @(negedge clk);
    end
    wait_q(0, exp.size(), 2000);
    repeat (600) @(negedge clk);
    chk("rnd_count", q0.size(), exp.size());
    check_frames(0, "rnd_frame", exp);
    chk("rnd_ferr", ferr0, any_bad);
    chk("rnd_led", led0, last_good);
    chk("rnd_ovr", ovr0, 1'b0);
    pulse_clr();
    chk("rnd_clr_ferr", ferr0, 1'b0);

    // framing error then glitch
    q0.delete(); st0.delete();
    b = led0;
    send_byte(0, 8'h3C, 1'b0);
    repeat (2*RX_DIV) @(negedge clk);
    chk("ferr_set", ferr0, 1'b1);
    chk("ferr_led", led0, b);
    repeat (700) @(negedge clk);
    chk("ferr_no_tx", q0.size(), 0);
    pulse_clr();
    chk("ferr_clr", ferr0, 1'b0);
    rxd0 = 1'b0;
    repeat (10) @(negedge clk);
    rxd0 = 1'b1;
    repeat (1200) @(negedge clk);
    chk("glitch_flags", {ferr0, ovr0}, 2'b00);
    chk("glitch_no_tx", q0.size(), 0);
    chk("glitch_lvl", lvl0, 0);

    // overrun on the slow, shallow instance
    q1.delete(); exp.delete();
    for (int i = 0; i < 7; i++) send_byte(1, 8'h11 + 8'(i), 1'b1);
    for (int i = 0; i < 6; i++) exp.push_back(8'h11 + 8'(i));
    chk("ovr_set", ovr1, 1'b1);
    wait_q(1, 6, 20000);
    repeat (600) @(negedge clk);
    chk("ovr_count", q1.size(), 6);
    check_frames(1, "ovr_frame", exp);
    chk("ovr_led", led1, 8'h16);
    chk("ovr_lvl", lvl1, 0);
    pulse_clr();
    chk("ovr_clr", ovr1, 1'b0);

    // reset in the middle of a coded frame
    q0.delete(); st0.delete();
    send_byte(0, 8'h77, 1'b1);
    f = 0;
    while (txd0 !== 1'b0 && f < 200) begin @(posedge clk); f++; end
    if (f >= 200) chk("mid_start_timeout", f, 0);
    repeat (5*TX_DIV0 + 20) @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", txd0, 1'b1);
    chk("mid_rst_lvl", lvl0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    q0.delete(); st0.delete(); exp.delete();
    send_byte(0, 8'h5A, 1'b1);
    exp.push_back(8'h5A);
    wait_q(0, 1, 1500);
    check_frames(0, "post_rst_frame", exp);
    chk("post_rst_led", led0, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
